// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake bundle for the UART transmitter.
// The master side supplies the byte and start strobe; the slave side (uart_tx)
// returns the serial line and its status flags.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;
  logic       tx_ready;

  modport master (
    output tx_start,
    output tx_byte,
    input  tx_serial,
    input  tx_active,
    input  tx_done,
    input  tx_ready
  );

  modport slave (
    input  tx_start,
    input  tx_byte,
    output tx_serial,
    output tx_active,
    output tx_done,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, one stop bit,
// each bit held for CLKS_PER_BIT clocks. Line idles high. The serial line and
// the active/done flags are registered from the next-state values so they
// change exactly on the edge that enters a new bit; tx_ready is a decode of
// the current state and is high only while idle.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BIT  = 3'd2,
    STOP_BIT  = 3'd3,
    CLEANUP   = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [2:0]    index_reg, index_next;
  logic [7:0]    shift_reg, shift_next;
  logic          serial_reg, serial_next;
  logic          active_reg, active_next;
  logic          done_reg, done_next;
  logic          bit_end;

  assign bit_end = (count_reg == CNT_LAST);

  // State, counters, data and registered line outputs; reset forces an idle line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      index_reg  <= '0;
      shift_reg  <= '0;
      serial_reg <= 1'b1;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      index_reg  <= index_next;
      shift_reg  <= shift_next;
      serial_reg <= serial_next;
      active_reg <= active_next;
      done_reg   <= done_next;
    end
  end

  // Next-state logic: accept in IDLE, then walk start/data/stop on baud-counter bit ends.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    index_next = index_reg;
    shift_next = shift_reg;
    case (state_reg)
      IDLE: begin
        count_next = '0;
        if (bus.tx_start) begin
          shift_next = bus.tx_byte;
          index_next = '0;
          state_next = START_BIT;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          count_next = '0;
          state_next = DATA_BIT;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
      DATA_BIT: begin
        if (bit_end) begin
          count_next = '0;
          if (index_reg == 3'd7) begin
            state_next = STOP_BIT;
          end else begin
            index_next = index_reg + 3'd1;
          end
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          count_next = '0;
          state_next = CLEANUP;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
      CLEANUP: begin
        count_next = '0;
        state_next = IDLE;
      end
      default: begin
        count_next = '0;
        index_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Output decode from the state being entered, so the registered line is glitch-free.
  always_comb begin
    serial_next = 1'b1;
    active_next = 1'b0;
    done_next   = 1'b0;
    case (state_next)
      START_BIT: begin
        serial_next = 1'b0;
        active_next = 1'b1;
      end
      DATA_BIT: begin
        serial_next = shift_next[index_next];
        active_next = 1'b1;
      end
      STOP_BIT: begin
        serial_next = 1'b1;
        active_next = 1'b1;
      end
      CLEANUP: begin
        done_next = 1'b1;
      end
      default: begin
        serial_next = 1'b1;
        active_next = 1'b0;
        done_next   = 1'b0;
      end
    endcase
  end

  assign bus.tx_serial = serial_reg;
  assign bus.tx_active = active_reg;
  assign bus.tx_done   = done_reg;
  assign bus.tx_ready  = (state_reg == IDLE);

endmodule
